// File: rtl/ad7763_cfg_sequencer_if.sv
// Command channel between the configuration sequencer and the AD7763 serial writer.
interface ad7763_cfg_sequencer_if;
  localparam int unsigned CMD_W = 32;

  logic [CMD_W-1:0] cmd_tdata;
  logic             cmd_tvalid;
  logic             cmd_tready;
  logic             wr_done;

  // Sequencer side: issues words, observes acceptance and completion
  modport master (
    output cmd_tdata,
    output cmd_tvalid,
    input  cmd_tready,
    input  wr_done
  );

  // Serial writer side
  modport slave (
    input  cmd_tdata,
    input  cmd_tvalid,
    output cmd_tready,
    output wr_done
  );
endinterface

// File: rtl/ad7763_cfg_sequencer.sv
// AD7763 power-up/reconfiguration sequencer: streams register words from a table to the
// serial writer, pulses SYNC, waits for the decimation filter to settle, then enables capture.
module ad7763_cfg_sequencer #(
  parameter int unsigned N_WORDS        = 3,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned SYNC_CYCLES    = 8,
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                        i_clk100,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic                        i_abort,
  output logic [ADDR_W-1:0]           o_tbl_addr,
  input  logic [31:0]                 i_tbl_data,
  ad7763_cfg_sequencer_if.master      cmd,
  output logic                        o_sync_n,
  output logic                        o_stream_en,
  output logic                        o_busy,
  output logic                        o_error
);

  localparam int unsigned MAX_AB  = (GAP_CYCLES > SYNC_CYCLES) ? GAP_CYCLES : SYNC_CYCLES;
  localparam int unsigned MAX_CD  = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_DONE,
    S_GAP,
    S_SYNC,
    S_SETTLE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_idx;
  logic [ADDR_W-1:0]  r_tbl_addr;
  logic [31:0]        r_cmd_tdata;
  logic               r_cmd_tvalid;
  logic               r_sync_n;
  logic               r_stream_en;
  logic               r_busy;
  logic               r_error;

  assign o_tbl_addr     = r_tbl_addr;
  assign cmd.cmd_tdata  = r_cmd_tdata;
  assign cmd.cmd_tvalid = r_cmd_tvalid;
  assign o_sync_n       = r_sync_n;
  assign o_stream_en    = r_stream_en;
  assign o_busy         = r_busy;
  assign o_error        = r_error;

  // Sequencer FSM; every output is updated together with the state it belongs to
  always_ff @(posedge i_clk100) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_tbl_addr   <= '0;
      r_cmd_tdata  <= '0;
      r_cmd_tvalid <= 1'b0;
      r_sync_n     <= 1'b1;
      r_stream_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
    end else if (i_abort) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cmd_tvalid <= 1'b0;
      r_sync_n     <= 1'b1;
      r_stream_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (i_start) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_tbl_addr  <= '0;
            r_stream_en <= 1'b0;
            r_busy      <= 1'b1;
            r_error     <= 1'b0;
          end
        end
        S_LOAD: begin
          r_cmd_tdata  <= i_tbl_data;
          r_cmd_tvalid <= 1'b1;
          r_state      <= S_SEND;
        end
        S_SEND: begin
          if (r_cmd_tvalid && cmd.cmd_tready) begin
            r_cmd_tvalid <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // a completion arriving on the final allowed cycle still counts as success
          if (cmd.wr_done) begin
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
            r_cnt <= '0;
            if (r_idx < ADDR_W'(N_WORDS - 1)) begin
              r_idx      <= r_idx + ADDR_W'(1);
              r_tbl_addr <= r_idx + ADDR_W'(1);
              r_state    <= S_LOAD;
            end else begin
              r_sync_n <= 1'b0;
              r_state  <= S_SYNC;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SYNC: begin
          if (r_cnt == CNT_W'(SYNC_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_sync_n <= 1'b1;
            r_state  <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_cnt       <= '0;
            r_stream_en <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_RUN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
